// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// byte-lane mask helpers.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic {
      IDLE   = 1'b0,
      SECOND = 1'b1
   } state_e;

   // Number of bytes moved by an access of the given size.
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      logic [3:0] n;
      case (size)
         SZ_B:    n = 4'd1;
         SZ_H:    n = 4'd2;
         SZ_W:    n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   // Byte lanes offset..offset+count-1 of one doubleword; lanes past 7 are dropped.
   function automatic logic [7:0] byte_mask(input logic [2:0] offset, input logic [3:0] count);
      logic [7:0] m;
      m = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i >= 32'(offset) && i < 32'(offset) + 32'(count))
            m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/lsu_extend.sv
// Right-justifies a load value by a byte offset and sign/zero-extends it
// from the given byte count to 64 bits.
module lsu_extend (
   input  logic [63:0] data,
   input  logic [2:0]  shift,
   input  logic [3:0]  count,
   input  logic        sign_ext,
   output logic [63:0] result
);

   logic [63:0] aligned;
   logic        fill_bit;

   // Shift the wanted bytes down, then fill everything above them.
   always_comb begin
      aligned  = data >> {shift, 3'b000};
      fill_bit = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (32'(count) == i + 1)
            fill_bit = sign_ext & aligned[8*i+7];
      end
      result = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         result[8*i +: 8] = (i < 32'(count)) ? aligned[8*i +: 8] : {8{fill_bit}};
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end: byte-addressed B/H/W/D accesses mapped onto a
// doubleword memory, with store byte-merge, load extension and a two-cycle
// split for accesses that cross an 8-byte boundary.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_DEPTH = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        stall,
   output logic        rsp_valid,
   output logic [63:0] rsp_rdata,
   output logic        fault,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [63:0] mem_rdata
);

   state_e      state;
   logic [2:0]  off;
   logic [3:0]  nbytes;
   logic [63:0] w0;
   logic [63:0] w1;
   logic        crosses;
   logic        out_of_range;

   logic [63:0] sec_addr;
   logic [63:0] sec_wdata;
   logic [63:0] cap_data;
   logic [2:0]  sec_off;
   logic [3:0]  sec_cnt;
   logic [3:0]  sec_rem;
   logic        sec_write;
   logic        sec_signed;

   logic [63:0] ins_data;
   logic [7:0]  ins_mask;
   logic [63:0] ext_data;
   logic [2:0]  ext_shift;
   logic [3:0]  ext_count;
   logic        ext_signed;
   logic [63:0] ext_out;

   // Decode the incoming request into word indices, boundary crossing and fault.
   always_comb begin
      off          = req_addr[2:0];
      nbytes       = size_bytes(req_size);
      w0           = {3'b000, req_addr[63:3]};
      w1           = w0 + 64'd1;
      crosses      = ({1'b0, off} + nbytes) > 4'd8;
      out_of_range = (w0 >= 64'(MEM_DEPTH)) || (crosses && (w1 >= 64'(MEM_DEPTH)));
      sec_rem      = {1'b0, sec_off} + sec_cnt - 4'd8;
   end

   // Drive the memory port, stall and the shared extender for the current cycle.
   always_comb begin
      mem_addr   = w0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      stall      = 1'b0;
      ins_data   = '0;
      ins_mask   = '0;
      ext_data   = mem_rdata;
      ext_shift  = off;
      ext_count  = nbytes;
      ext_signed = req_signed;
      if (state == SECOND) begin
         // Tail of a split access: lanes 0.. of the next word, captured head glued below.
         mem_addr   = sec_addr;
         mem_read   = ~reset;
         mem_write  = sec_write & ~reset;
         ins_data   = sec_wdata;
         ins_mask   = byte_mask(3'd0, sec_rem);
         ext_data   = cap_data | (mem_rdata << {4'd8 - {1'b0, sec_off}, 3'b000});
         ext_shift  = '0;
         ext_count  = sec_cnt;
         ext_signed = sec_signed;
      end else if (req_valid && !out_of_range) begin
         // Shifting left drops the bytes that spill into the next word on a split.
         mem_read  = ~reset;
         mem_write = req_write & ~reset;
         ins_data  = req_wdata << {off, 3'b000};
         ins_mask  = byte_mask(off, nbytes);
         stall     = crosses;
      end
      for (int unsigned i = 0; i < 8; i++) begin
         mem_wdata[8*i +: 8] = ins_mask[i] ? ins_data[8*i +: 8] : mem_rdata[8*i +: 8];
      end
   end

   lsu_extend u_extend (
      .data     (ext_data),
      .shift    (ext_shift),
      .count    (ext_count),
      .sign_ext (ext_signed),
      .result   (ext_out)
   );

   // Request FSM: registers responses and carries split-access context to SECOND.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         fault      <= 1'b0;
         sec_addr   <= '0;
         sec_wdata  <= '0;
         cap_data   <= '0;
         sec_off    <= '0;
         sec_cnt    <= '0;
         sec_write  <= 1'b0;
         sec_signed <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         fault     <= 1'b0;
         rsp_rdata <= '0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (out_of_range) begin
                     rsp_valid <= 1'b1;
                     fault     <= 1'b1;
                  end else if (crosses) begin
                     state      <= SECOND;
                     sec_addr   <= w1;
                     sec_off    <= off;
                     sec_cnt    <= nbytes;
                     sec_write  <= req_write;
                     sec_signed <= req_signed;
                     sec_wdata  <= req_wdata >> {4'd8 - {1'b0, off}, 3'b000};
                     cap_data   <= mem_rdata >> {off, 3'b000};
                  end else begin
                     rsp_valid <= 1'b1;
                     if (!req_write)
                        rsp_rdata <= ext_out;
                  end
               end
            end
            SECOND: begin
               state     <= IDLE;
               rsp_valid <= 1'b1;
               if (!sec_write)
                  rsp_rdata <= ext_out;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_load_store_unit;

   localparam int DEPTH = 128;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        fault;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .fault      (fault),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_rdata  (mem_rdata)
   );

   // Data memory the DUT talks to.
   logic [63:0] mem [0:DEPTH-1];
   logic        pl_en;
   logic [6:0]  pl_idx;
   logic [63:0] pl_data;

   assign mem_rdata = (mem_addr < 64'(DEPTH)) ? mem[mem_addr[6:0]] : '0;

   always @(posedge clk) begin
      if (pl_en)
         mem[pl_idx] <= pl_data;
      else if (mem_write && mem_addr < 64'(DEPTH))
         mem[mem_addr[6:0]] <= mem_wdata;
   end

   // Reference model state: plain byte-addressed memory.
   logic [7:0] ref_mem [0:DEPTH*8-1];

   typedef struct {
      int unsigned due;
      logic [63:0] rd;
      bit          flt;
   } exp_t;
   exp_t q[$];

   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned cyc = 0;
   bit          run = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%h required=0x%h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Single compare process: every cycle, either the predicted response or silence.
   always @(negedge clk) begin
      if (run) begin
         if (q.size() > 0 && q[0].due == cyc) begin
            check("rsp_valid", 64'(rsp_valid), 64'd1);
            check("rsp_rdata", rsp_rdata, q[0].rd);
            check("rsp_fault", 64'(fault), 64'(q[0].flt));
            void'(q.pop_front());
         end else begin
            check("rsp_idle", 64'(rsp_valid), 64'd0);
         end
      end
   end

   // Behavioural model of one access; first_only models a reset that kills the tail.
   task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd, input bit first_only,
                        output logic [63:0] rd, output bit flt, output bit split);
      int unsigned o;
      int unsigned n;
      int          base;
      logic [63:0] wi;
      logic [63:0] v;
      o     = 32'(a[2:0]);
      n     = 1 << sz;
      wi    = a >> 3;
      split = (o + n) > 8;
      flt   = (wi >= 64'(DEPTH)) || (split && (wi + 64'd1 >= 64'(DEPTH)));
      rd    = '0;
      base  = int'(a[9:0]);
      if (flt) begin
         split = 1'b0;
      end else if (w) begin
         for (int unsigned i = 0; i < n; i++) begin
            if (!first_only || i < 8 - o)
               ref_mem[base + int'(i)] = wd[8*i +: 8];
         end
      end else begin
         v = '0;
         for (int unsigned i = 0; i < n; i++)
            v[8*i +: 8] = ref_mem[base + int'(i)];
         if (sg && n < 8 && v[8*n-1]) begin
            for (int unsigned i = n; i < 8; i++)
               v[8*i +: 8] = 8'hFF;
         end
         rd = v;
      end
   endtask

   // Present one request from just after a rising edge; returns just after the
   // rising edge that ends it.
   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd, input bit rst_mid,
                        output logic [63:0] rd, output bit flt);
      bit   split;
      exp_t e;
      model(w, sz, sg, a, wd, rst_mid, rd, flt, split);
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      @(negedge clk);
      check("stall", 64'(stall), 64'(split));
      if (flt)
         check("fault_no_write", 64'(mem_write), 64'd0);
      if (!rst_mid) begin
         e.due = cyc + (split ? 2 : 1);
         e.rd  = rd;
         e.flt = flt;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (split) begin
         // Junk on the request bus while the tail runs; it must be ignored.
         req_valid = 1'b1;
         req_write = 1'($urandom);
         req_addr  = {$urandom, $urandom};
         req_wdata = {$urandom, $urandom};
         if (rst_mid) begin
            reset = 1'b1;
            @(negedge clk);
            check("reset_mid_no_write", 64'(mem_write), 64'd0);
            @(posedge clk);
            #1;
            reset = 1'b0;
         end else begin
            @(negedge clk);
            check("second_stall", 64'(stall), 64'd0);
            @(posedge clk);
            #1;
         end
         req_valid = 1'b0;
      end
   endtask

   task automatic idle(input int unsigned cycles);
      req_valid = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] rd;
      logic [63:0] v;
      bit          fl;
      int unsigned r;
      logic [63:0] a;

      reset      = 1'b1;
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_size   = 2'd3;
      req_signed = 1'b0;
      req_addr   = 64'h40;
      req_wdata  = '1;
      pl_en      = 1'b0;
      pl_idx     = '0;
      pl_data    = '0;
      @(posedge clk);
      #1;

      // Preload both memories while reset holds the DUT.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         case (i)
            1:       v = 64'h0;
            2:       v = 64'h8877665544332211;
            3:       v = 64'h00000000000000AA;
            4:       v = 64'h0123456789ABCDEF;
            default: v = {$urandom, $urandom};
         endcase
         for (int unsigned b = 0; b < 8; b++)
            ref_mem[8*i + b] = v[8*b +: 8];
         pl_en   = 1'b1;
         pl_idx  = 7'(i);
         pl_data = v;
         @(posedge clk);
         #1;
      end
      pl_en = 1'b0;

      @(negedge clk);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_rdata", rsp_rdata, 64'd0);
      check("reset_fault", 64'(fault), 64'd0);
      check("reset_mem_write", 64'(mem_write), 64'd0);
      check("reset_mem_read", 64'(mem_read), 64'd0);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      req_valid = 1'b0;
      run       = 1'b1;

      issue(1'b0, 2'd3, 1'b0, 64'h10, '0, 1'b0, rd, fl);
      check("model_ld_d", rd, 64'h8877665544332211);
      issue(1'b0, 2'd0, 1'b1, 64'h17, '0, 1'b0, rd, fl);
      check("model_ldursb", rd, 64'hFFFFFFFFFFFFFF88);
      issue(1'b0, 2'd0, 1'b0, 64'h17, '0, 1'b0, rd, fl);
      check("model_ldurb", rd, 64'h0000000000000088);
      issue(1'b0, 2'd1, 1'b1, 64'h17, '0, 1'b0, rd, fl);
      check("model_ldursh_split", rd, 64'hFFFFFFFFFFFFAA88);

      issue(1'b1, 2'd2, 1'b0, 64'h0E, 64'hDEADBEEF, 1'b0, rd, fl);
      check("store_split_w1", mem[1], 64'hBEEF000000000000);
      check("store_split_w2", mem[2], 64'h887766554433DEAD);

      issue(1'b0, 2'd3, 1'b0, 64'h3FC, '0, 1'b0, rd, fl);
      check("model_fault_cross", 64'(fl), 64'd1);
      issue(1'b1, 2'd3, 1'b0, 64'h640, 64'hFFFF, 1'b0, rd, fl);
      check("model_fault_store", 64'(fl), 64'd1);

      issue(1'b1, 2'd3, 1'b0, 64'h1C, 64'h1122334455667788, 1'b1, rd, fl);
      check("reset_mid_w3", mem[3], 64'h55667788000000AA);
      check("reset_mid_w4", mem[4], 64'h0123456789ABCDEF);
      issue(1'b0, 2'd3, 1'b0, 64'h20, '0, 1'b0, rd, fl);
      check("model_after_reset", rd, 64'h0123456789ABCDEF);

      for (int unsigned k = 0; k < 400; k++) begin
         r = $urandom_range(0, 99);
         if (r < 88)
            a = 64'($urandom_range(0, DEPTH*8 - 1));
         else if (r < 96)
            a = 64'($urandom_range(DEPTH*8 - 8, DEPTH*8 + 80));
         else
            a = {$urandom, $urandom};
         issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a,
               {$urandom, $urandom}, 1'b0, rd, fl);
         if ($urandom_range(0, 3) == 0)
            idle($urandom_range(1, 3));
      end

      idle(4);
      check("queue_drained", 64'(q.size()), 64'd0);
      for (int unsigned i = 0; i < DEPTH; i++) begin
         for (int unsigned b = 0; b < 8; b++)
            v[8*b +: 8] = ref_mem[8*i + b];
         check("final_mem", mem[i], v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage front end sitting directly upstream of the doubleword-indexed data memory.
- Turns byte-addressed LDUR/STUR-family requests into doubleword memory accesses:
  - sizes: B, H, W, D;
  - zero or sign extension on loads;
  - byte-merge on stores;
  - automatic two-cycle split for accesses crossing an 8-byte boundary.
- Feeds the data memory and produces registered load results for the MEM/WB register.

Parameters:
- MEM_DEPTH, 128, number of 64-bit words in data memory; word indices at or above this fault.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  memory request present this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
- req_signed  in  1  sign-extend load result (LDURSW/LDURSH/LDURSB).
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-justified.
- stall  out  1  combinational; pipeline must hold the request and freeze while high.
- rsp_valid  out  1  registered; one-cycle pulse, result of a completed request.
- rsp_rdata  out  64  registered load result (0 for stores and faults).
- fault  out  1  registered; pulses with rsp_valid on an out-of-range access.
- mem_addr  out  64  word index to data memory.
- mem_wdata  out  64  merged doubleword to write.
- mem_read  out  1  read enable.
- mem_write  out  1  write enable; memory writes on the rising edge.
- mem_rdata  in  64  combinational read data from memory.

Behaviour:
- Clock/reset:
  - Single clock `clk`; synchronous active-high `reset`.
  - Reset: state=IDLE, rsp_valid=0, rsp_rdata=0, fault=0, capture registers=0.
  - mem_write and mem_read are forced 0 during any cycle with reset high.
- Address decode:
  - Little-endian. o = req_addr[2:0], n = 1<<req_size, w0 = req_addr>>3.
  - crosses = (o+n > 8), giving w1 = w0+1.
  - Fault when w0 ≥ MEM_DEPTH, or when crosses and w1 ≥ MEM_DEPTH.
- IDLE, req_valid=1, no fault, not crosses:
  - mem_addr = w0, mem_read = 1.
  - Store: mem_write = 1, mem_wdata = mem_rdata with bytes o..o+n-1 replaced by req_wdata[8n-1:0].
  - Next edge: rsp_valid = 1; for loads, rsp_rdata = extended bytes o..o+n-1 of mem_rdata.
  - stall = 0. Latency is one cycle.
- IDLE, req_valid=1, crosses (not fault):
  - stall = 1 for exactly this cycle.
  - Access w0:
    - Store: write bytes o..7 from the low (8-o) bytes of req_wdata.
    - Load: capture bytes o..7.
  - Latch w1, size, signedness, remaining store bytes and the byte count; go to SECOND.
- SECOND:
  - stall = 0. Access w1 from latched values, bytes 0..(o+n-9).
  - Store: merge the remaining bytes.
  - Load: concatenate captured and new bytes, then extend.
  - Next edge: rsp_valid = 1; state → IDLE.
  - req_* are ignored in this cycle. The pipeline advances at this edge and the new request is seen next cycle.
- Fault:
  - No mem_write.
  - Next edge: rsp_valid = 1, fault = 1, rsp_rdata = 0. Never splits.
- Extension: signed → replicate bit 8n-1 up to bit 63; unsigned → zero-fill. Size D ignores req_signed.
- Idle cycles: req_valid = 0 → mem_read = 0, mem_write = 0, rsp_valid = 0 next edge.
- Reset mid-SECOND: second-word write suppressed (first word stays written), no rsp_valid, state → IDLE.
- Store responses: rsp_rdata = 0, fault = 0 unless faulted.

Decomposition:
- Shared package `lsu_pkg`:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state enum IDLE/SECOND;
  - function `byte_mask(offset, count)`.
- One sub-module `lsu_extend`:
  - combinational right-justify plus sign/zero extension from a byte count;
  - shared by the single-word and split load paths.

Test Plan:
- Memory word 2 = 0x8877665544332211; load D at byte address 0x10 → rsp_valid next cycle, rdata 0x8877665544332211, stall never high.
- Signed byte load at 0x17 → rdata 0xFFFFFFFFFFFFFF88; unsigned → 0x0000000000000088.
- Word 2 as above, word 3 = 0x00000000000000AA; signed half load at 0x17 → stall high one cycle, rdata 0xFFFFFFFFFFFFAA88.
- Store W 0xDEADBEEF at byte address 0x0E (word 1 initially 0):
  - word 1 becomes 0xBEEF000000000000;
  - word 2 low half becomes 0xDEAD with its upper bytes preserved;
  - one stall cycle.
- Load at word index 127 crossing into 128 (MEM_DEPTH = 128), and store at word index 200 → fault = 1, rsp_rdata = 0, no mem_write asserted.
- Reset asserted in the SECOND cycle of a crossing store → first word modified, second untouched, no rsp_valid, state IDLE, next aligned load completes normally.
